// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing generator with registered hsync/vsync/blank/x/y and strobes.
// Optional half-rate advance with pix_en output when VGA_TIMING_CLKDIV_EN is defined.
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 800,
  parameter int   H_FPORCH  = 24,
  parameter int   H_SYNC    = 72,
  parameter int   H_BPORCH  = 128,
  parameter int   V_ACTIVE  = 600,
  parameter int   V_FPORCH  = 1,
  parameter int   V_SYNC    = 2,
  parameter int   V_BPORCH  = 22,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
`ifdef VGA_TIMING_CLKDIV_EN
  ,
  output logic       pix_en
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FPORCH + H_SYNC + H_BPORCH;
  localparam int V_TOTAL = V_ACTIVE + V_FPORCH + V_SYNC + V_BPORCH;
  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS  = 10'(H_ACTIVE + H_FPORCH);
  localparam logic [9:0] H_SE  = 10'(H_ACTIVE + H_FPORCH + H_SYNC);
  localparam logic [9:0] V_SS  = 10'(V_ACTIVE + V_FPORCH);
  localparam logic [9:0] V_SE  = 10'(V_ACTIVE + V_FPORCH + V_SYNC);

  logic [9:0] h_cnt, v_cnt;
  logic [7:0] f_cnt;
  logic       en, h_last, v_last;

`ifdef VGA_TIMING_CLKDIV_EN
  logic tog;
  // half-rate toggle: counters and outputs advance only when it is 1
  always_ff @(posedge clk) tog <= rst_n ? ~tog : 1'b0;
  assign en     = tog;
  assign pix_en = tog;
`else
  assign en = 1'b1;
`endif

  assign h_last = h_cnt == H_MAX;
  assign v_last = v_cnt == V_MAX;

  // raster position counters and completed-frame counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      f_cnt <= '0;
    end else if (en) begin
      h_cnt <= h_last ? '0 : h_cnt + 10'd1;
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + 10'd1;
      if (h_last && v_last) f_cnt <= f_cnt + 8'd1;
    end
  end

  // registered decode of the previous counter values; strobes last a single clk
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      blank       <= 1'b1;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      line_start  <= en && h_cnt == '0;
      frame_start <= en && h_cnt == '0 && v_cnt == '0;
      if (en) begin
        x           <= h_cnt;
        y           <= v_cnt;
        blank       <= !(h_cnt < H_ACT && v_cnt < V_ACT);
        hsync       <= (h_cnt >= H_SS && h_cnt < H_SE) ? HSYNC_POL : ~HSYNC_POL;
        vsync       <= (v_cnt >= V_SS && v_cnt < V_SE) ? VSYNC_POL : ~VSYNC_POL;
        frame_count <= f_cnt;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized-reset check of vga_timing_gen against a cycle-index raster model.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2;
  localparam logic HP = 1'b1, VP = 1'b0;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync, vsync, blank, line_start, frame_start;
  logic [9:0] x, y;
  logic [7:0] frame_count;
  int         checks = 0, errors = 0;
  int         n = 0;
  int         fs_seen = 0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FPORCH(HF), .H_SYNC(HS), .H_BPORCH(HB),
    .V_ACTIVE(VA), .V_FPORCH(VF), .V_SYNC(VS), .V_BPORCH(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .blank(blank),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // n = number of clock edges seen with reset released
  always @(posedge clk) n <= rst_n ? n + 1 : 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got %0d exp %0d", tag, n, got, exp);
    end
  endtask

  task automatic check_cycle();
    int pos, ex, ey, efc;
    if (n == 0) begin
      check("rst_x", 32'(x), 0);
      check("rst_y", 32'(y), 0);
      check("rst_blank", 32'(blank), 1);
      check("rst_hsync", 32'(hsync), 32'(!HP));
      check("rst_vsync", 32'(vsync), 32'(!VP));
      check("rst_ls", 32'(line_start), 0);
      check("rst_fs", 32'(frame_start), 0);
      check("rst_fc", 32'(frame_count), 0);
    end else begin
      pos = (n - 1) % FR;
      ex  = pos % HT;
      ey  = pos / HT;
      efc = ((n - 1) / FR) % 256;
      check("x", 32'(x), 32'(ex));
      check("y", 32'(y), 32'(ey));
      check("blank", 32'(blank), 32'(!(ex < HA && ey < VA)));
      check("hsync", 32'(hsync), 32'((ex >= HA + HF && ex < HA + HF + HS) ? HP : !HP));
      check("vsync", 32'(vsync), 32'((ey >= VA + VF && ey < VA + VF + VS) ? VP : !VP));
      check("line_start", 32'(line_start), 32'(ex == 0));
      check("frame_start", 32'(frame_start), 32'(pos == 0));
      check("frame_count", 32'(frame_count), 32'(efc));
    end
  endtask

  initial begin
    int hold;
    repeat (3) begin
      @(negedge clk);
      check_cycle();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 256 * FR + 3 * FR; i++) begin
      @(negedge clk);
      check_cycle();
      if (n <= 256 * FR && frame_start) fs_seen++;
    end
    check("fs_pulses_256_frames", 32'(fs_seen), 256);
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      check_cycle();
      if (hold > 0) begin
        hold--;
        rst_n = hold == 0;
      end else if ($urandom_range(0, 199) == 0) begin
        hold = $urandom_range(1, 3);
        rst_n = 1'b0;
      end
    end
    rst_n = 1'b1;
    repeat (2 * FR) begin
      @(negedge clk);
      check_cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
